pc_trace_buffer: RTL and testbench

- Parametrised on-chip trace capture for the Microprocessor. It generalises the fixed probe taps (PC, instruction, ALU result, memory address) into N_CH configurable probe channels.
- Records up to DEPTH samples into a circular buffer. Capture stops a programmable number of samples after the PC matches a trigger address.
- Captured history is replayed oldest-first, so a bench or debug port can inspect execution without per-signal test wires.

---
 rtl/pc_trace_buffer.sv | 191 +++++++++++++++++++
 tb/tb_pc_trace_buffer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_trace_buffer.sv
// pc_trace_buffer: circular trace capture of {PC, probe channels} with a PC trigger,
// post-trigger sample count and oldest-first replay. Define TRACE_TIMESTAMP_EN for per-entry cycle stamps.
module pc_trace_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 6,
    parameter int unsigned N_CH   = 2,
    parameter int unsigned DEPTH  = 16,
`ifdef TRACE_TIMESTAMP_EN
    parameter int unsigned TS_W   = 16,
`endif
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   arm,
    input  logic [PC_W-1:0]        trig_pc,
    input  logic [AW-1:0]          post_cnt,
    input  logic                   valid_in,
    input  logic [PC_W-1:0]        pc_in,
    input  logic [N_CH*DATA_W-1:0] probe_in,
    input  logic                   rd_req,
    output logic                   armed,
    output logic                   triggered,
    output logic                   done,
    output logic [AW:0]            fill_level,
    output logic                   rd_valid,
    output logic                   rd_last,
    output logic [PC_W-1:0]        rd_pc,
    output logic [N_CH*DATA_W-1:0] rd_data
`ifdef TRACE_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]        rd_ts
`endif
);

    localparam int unsigned PW = N_CH * DATA_W;
`ifdef TRACE_TIMESTAMP_EN
    localparam int unsigned EW = TS_W + PC_W + PW;
`else
    localparam int unsigned EW = PC_W + PW;
`endif

    typedef enum logic [2:0] {IDLE, ARMED, POST, DONE, READ} state_t;

    state_t          state, next_state;
    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr, remaining, post_lat;
    logic [AW:0]     count, rd_left;
    logic            wr_en, restart, trig_hit, rd_start, rd_issue;
    logic [EW-1:0]   wr_entry, rd_entry;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts;
    assign wr_entry = {ts, pc_in, probe_in};
`else
    assign wr_entry = {pc_in, probe_in};
`endif

    assign rd_entry   = mem[rd_ptr];
    assign rd_issue   = (state == READ) && (rd_left != '0);
    assign fill_level = count;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        wr_en      = 1'b0;
        restart    = 1'b0;
        trig_hit   = 1'b0;
        rd_start   = 1'b0;
        case (state)
            IDLE: begin
                if (arm) begin
                    restart    = 1'b1;
                    next_state = ARMED;
                end
            end
            ARMED: begin
                if (arm) begin
                    restart    = 1'b1;
                    next_state = ARMED;
                end else if (valid_in) begin
                    wr_en = 1'b1;
                    if (pc_in == trig_pc) begin
                        trig_hit   = 1'b1;
                        next_state = (post_lat == '0) ? DONE : POST;
                    end
                end
            end
            POST: begin
                if (arm) begin
                    restart    = 1'b1;
                    next_state = ARMED;
                end else if (valid_in) begin
                    wr_en = 1'b1;
                    if (remaining == AW'(1)) next_state = DONE;
                end
            end
            DONE: begin
                if (arm) begin
                    restart    = 1'b1;
                    next_state = ARMED;
                end else if (rd_req && (count != '0)) begin
                    rd_start   = 1'b1;
                    next_state = READ;
                end
            end
            READ: begin
                if (rd_left == '0) next_state = DONE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr    <= '0;
            count     <= '0;
            remaining <= '0;
            post_lat  <= '0;
            rd_ptr    <= '0;
            rd_left   <= '0;
            armed     <= 1'b0;
            triggered <= 1'b0;
            done      <= 1'b0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            rd_pc     <= '0;
            rd_data   <= '0;
`ifdef TRACE_TIMESTAMP_EN
            ts        <= '0;
            rd_ts     <= '0;
`endif
        end else begin
            armed <= (next_state == ARMED) || (next_state == POST);
            done  <= (next_state == DONE) || (next_state == READ);
`ifdef TRACE_TIMESTAMP_EN
            // the arm cycle itself is stamp 0, so the following cycle is stamp 1
            ts <= restart ? TS_W'(1) : ts + 1'b1;
`endif
            if (restart) begin
                wr_ptr    <= '0;
                count     <= '0;
                triggered <= 1'b0;
                post_lat  <= post_cnt;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (count != (AW+1)'(DEPTH)) count <= count + 1'b1;
                if (trig_hit) begin
                    triggered <= 1'b1;
                    remaining <= post_lat;
                end else if (state == POST) begin
                    remaining <= remaining - 1'b1;
                end
            end
            // a full buffer has count[AW-1:0]==0, so the oldest entry is at wr_ptr
            if (rd_start) begin
                rd_ptr  <= wr_ptr - count[AW-1:0];
                rd_left <= count;
            end
            if (rd_issue) begin
                rd_ptr   <= rd_ptr + 1'b1;
                rd_left  <= rd_left - 1'b1;
                rd_valid <= 1'b1;
                rd_last  <= (rd_left == (AW+1)'(1));
                rd_pc    <= rd_entry[PW +: PC_W];
                rd_data  <= rd_entry[PW-1:0];
`ifdef TRACE_TIMESTAMP_EN
                rd_ts    <= rd_entry[PC_W+PW +: TS_W];
`endif
            end else begin
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
                rd_pc    <= '0;
                rd_data  <= '0;
`ifdef TRACE_TIMESTAMP_EN
                rd_ts    <= '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_pc_trace_buffer.sv
// tb_pc_trace_buffer: table-driven capture scenarios plus hand sequences; a behavioural
// capture model fills a scoreboard queue that is drained against the replayed entries.
module tb_pc_trace_buffer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst, arm, valid_in, rd_req;
    logic [5:0]  trig_pc, pc_in;
    logic [3:0]  post_cnt;
    logic [63:0] probe_in;
    logic        armed, triggered, done, rd_valid, rd_last;
    logic [4:0]  fill_level;
    logic [5:0]  rd_pc;
    logic [63:0] rd_data;
`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] rd_ts;
`endif

    pc_trace_buffer #(.DATA_W(32), .PC_W(6), .N_CH(2), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .arm(arm), .trig_pc(trig_pc), .post_cnt(post_cnt),
        .valid_in(valid_in), .pc_in(pc_in), .probe_in(probe_in), .rd_req(rd_req),
        .armed(armed), .triggered(triggered), .done(done), .fill_level(fill_level),
        .rd_valid(rd_valid), .rd_last(rd_last), .rd_pc(rd_pc), .rd_data(rd_data)
`ifdef TRACE_TIMESTAMP_EN
        , .rd_ts(rd_ts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  pc;
        logic [63:0] data;
        logic [15:0] ts;
    } entry_t;

    typedef struct {
        int   trig;
        int   post;
        int   n;
        logic exp_done;
        logic exp_trig;
        int   exp_fill;
        int   exp_first;
    } vec_t;

    int     n_cmp = 0;
    int     n_bad = 0;
    entry_t m_q[$];
    int     m_phase = 2;
    int     m_rem, m_post, m_trig_pc, m_cyc;
    vec_t   vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // a valid trigger-PC sample in the arm cycle itself must not be captured
    task automatic do_arm(input int trig, input int post);
        arm = 1'b1; trig_pc = trig[5:0]; post_cnt = post[3:0];
        valid_in = 1'b1; pc_in = trig[5:0]; probe_in = '1;
        @(negedge clk);
        arm = 1'b0; valid_in = 1'b0;
        m_q.delete(); m_phase = 0; m_rem = 0; m_post = post; m_trig_pc = trig; m_cyc = 1;
    endtask

    task automatic drive(input logic v, input int pc);
        entry_t e;
        valid_in = v; pc_in = pc[5:0]; probe_in = {$urandom, $urandom};
        if (v && m_phase < 2) begin
            e.pc = pc[5:0]; e.data = probe_in; e.ts = m_cyc[15:0];
            if (m_q.size() == DEPTH) void'(m_q.pop_front());
            m_q.push_back(e);
            if (m_phase == 0) begin
                if (pc[5:0] == m_trig_pc[5:0]) begin
                    if (m_post == 0) m_phase = 2;
                    else begin m_phase = 1; m_rem = m_post; end
                end
            end else begin
                m_rem--;
                if (m_rem == 0) m_phase = 2;
            end
        end
        m_cyc++;
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic readout(input string tag, input int exp_first);
        entry_t sb[$];
        entry_t e;
        bit     fin = 0;
        bit     first = 1;
        sb = m_q;
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        chk({tag, "_lat1_valid"}, rd_valid, 0);
        for (int c = 0; c < DEPTH + 2 && !fin; c++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                chk({tag, "_end_valid"}, rd_valid, 0);
                chk({tag, "_end_done"}, done, 1);
                fin = 1;
            end else begin
                chk({tag, "_valid"}, rd_valid, 1);
                if (rd_valid) begin
                    e = sb.pop_front();
                    if (first) chk({tag, "_first_pc"}, rd_pc, exp_first);
                    first = 0;
                    chk({tag, "_pc"}, rd_pc, e.pc);
                    chk({tag, "_data"}, rd_data, e.data);
                    chk({tag, "_last"}, rd_last, (sb.size() == 0));
`ifdef TRACE_TIMESTAMP_EN
                    chk({tag, "_ts"}, rd_ts, e.ts);
`endif
                end
            end
        end
        if (!fin) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: %0d entries left, required 0", tag, sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required earlier $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            trig post  n  done trig fill first
        vecs[0] = '{   5,   3, 11, 1'b1, 1'b1,  9,  0};
        vecs[1] = '{  50,   1, 20, 1'b0, 1'b0, 16,  0};
        vecs[2] = '{  30,   2, 40, 1'b1, 1'b1, 16, 17};
        vecs[3] = '{   0,   0,  1, 1'b1, 1'b1,  1,  0};
        vecs[4] = '{   3,  15, 30, 1'b1, 1'b1, 16,  3};

        rst = 1'b0; arm = 1'b0; valid_in = 1'b0; rd_req = 1'b0;
        trig_pc = '0; pc_in = '0; post_cnt = '0; probe_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_armed", armed, 0);
        chk("rst_triggered", triggered, 0);
        chk("rst_done", done, 0);
        chk("rst_fill", fill_level, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_last", rd_last, 0);
        chk("rst_rd_pc", rd_pc, 0);
        chk("rst_rd_data", rd_data, 0);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_rdreq_valid", rd_valid, 0);
        chk("idle_rdreq_done", done, 0);

        for (int i = 0; i < 5; i++) begin
            do_arm(vecs[i].trig, vecs[i].post);
            for (int s = 0; s < vecs[i].n; s++) drive(1'b1, s % 64);
            chk($sformatf("v%0d_done", i), done, vecs[i].exp_done);
            chk($sformatf("v%0d_triggered", i), triggered, vecs[i].exp_trig);
            chk($sformatf("v%0d_fill", i), fill_level, vecs[i].exp_fill);
            chk($sformatf("v%0d_armed", i), armed, !vecs[i].exp_done);
            if (vecs[i].exp_done) begin
                readout($sformatf("v%0d_rd1", i), vecs[i].exp_first);
                readout($sformatf("v%0d_rd2", i), vecs[i].exp_first);
            end
        end

        // post count stalls on invalid cycles; a second arm in POST restarts capture
        do_arm(2, 4);
        drive(1'b1, 0); drive(1'b1, 1); drive(1'b1, 2);
        drive(1'b1, 3); drive(1'b0, 0); drive(1'b1, 4); drive(1'b0, 0);
        drive(1'b1, 5); drive(1'b0, 0);
        chk("post_stall_done", done, 0);
        chk("post_stall_armed", armed, 1);
        chk("post_stall_triggered", triggered, 1);
        chk("post_stall_fill", fill_level, 6);
        do_arm(2, 1);
        chk("rearm_triggered", triggered, 0);
        chk("rearm_fill", fill_level, 0);
        chk("rearm_armed", armed, 1);
        chk("rearm_done", done, 0);
        drive(1'b1, 7); drive(1'b1, 2); drive(1'b0, 0); drive(1'b1, 8);
        chk("rearm_done2", done, 1);
        chk("rearm_fill2", fill_level, 3);
        readout("rearm_rd", 7);

`ifdef TRACE_TIMESTAMP_EN
        do_arm(20, 2);
        drive(1'b1, 20); drive(1'b0, 0); drive(1'b1, 21); drive(1'b1, 22);
        chk("ts_done", done, 1);
        readout("ts_rd", 20);
`endif

        // reset in the middle of a readout aborts it
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("midread_valid", rd_valid, 1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midrst_valid", rd_valid, 0);
        chk("midrst_done", done, 0);
        chk("midrst_fill", fill_level, 0);
        @(negedge clk);
        chk("midrst_valid2", rd_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
